// File: rtl/sc_stream_decoder.sv
// Serial unipolar stochastic-to-binary converter: counts the ones in a stream of 2^LOG2_N
// accepted bits and presents the count and a saturated fixed-point probability.
module sc_stream_decoder #(
    parameter int LOG2_N = 14,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic              busy,
    output logic [LOG2_N:0]   ones_count,
    output logic [FRAC_W-1:0] prob_q,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // The bit counter is all ones exactly when the N-th bit is being accepted.
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    state_t              state_q, state_d;
    logic [LOG2_N-1:0]   cnt_q, cnt_d;
    logic [LOG2_N:0]     acc_q, acc_d;
    logic [LOG2_N:0]     ones_q, ones_d;
    logic [FRAC_W-1:0]   prob_q_q, prob_q_d;
    logic [LOG2_N:0]     acc_next;

    // A count of exactly N is the only value with the top bit set; it saturates to all ones.
    function automatic logic [FRAC_W-1:0] sat_quantize(input logic [LOG2_N:0] cnt);
        if (cnt[LOG2_N]) begin
            sat_quantize = '1;
        end else begin
            sat_quantize = cnt[LOG2_N-1 -: FRAC_W];
        end
    endfunction

    assign acc_next = acc_q + (LOG2_N+1)'(bit_in);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ones_d   = ones_q;
        prob_q_d = prob_q_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_ACCUM: begin
                if (bit_valid) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + LOG2_N'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        ones_d   = acc_next;
                        prob_q_d = sat_quantize(acc_next);
                    end
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    if (start) begin
                        state_d = ST_ACCUM;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            ones_q   <= '0;
            prob_q_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ones_q   <= ones_d;
            prob_q_q <= prob_q_d;
        end
    end

    assign busy         = (state_q == ST_ACCUM);
    assign bit_ready    = (state_q == ST_ACCUM);
    assign result_valid = (state_q == ST_DONE);
    assign ones_count   = ones_q;
    assign prob_q       = prob_q_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed plus randomized bench for sc_stream_decoder: two short-stream instances
// (LOG2_N=4 with FRAC_W=4 and 2) share stimulus, and one default-size instance.
module tb_sc_stream_decoder;

    logic clk;
    logic rst_s, rst_l;
    logic start, bit_in, bit_valid, result_ready;

    logic       br_a, busy_a, rv_a;
    logic [4:0] ones_a;
    logic [3:0] prob_a;
    logic       br_b, busy_b, rv_b;
    logic [4:0] ones_b;
    logic [1:0] prob_b;
    logic        br_c, busy_c, rv_c;
    logic [14:0] ones_c;
    logic [7:0]  prob_c;

    int tests = 0;
    int fails = 0;
    int model_ones = 0;

    sc_stream_decoder #(.LOG2_N(4), .FRAC_W(4)) u_a (
        .clk(clk), .rst(rst_s), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(br_a), .busy(busy_a), .ones_count(ones_a), .prob_q(prob_a),
        .result_valid(rv_a), .result_ready(result_ready));

    sc_stream_decoder #(.LOG2_N(4), .FRAC_W(2)) u_b (
        .clk(clk), .rst(rst_s), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(br_b), .busy(busy_b), .ones_count(ones_b), .prob_q(prob_b),
        .result_valid(rv_b), .result_ready(result_ready));

    sc_stream_decoder u_c (
        .clk(clk), .rst(rst_l), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(br_c), .busy(busy_c), .ones_count(ones_c), .prob_q(prob_c),
        .result_valid(rv_c), .result_ready(result_ready));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected probability: fraction ones/N truncated to fracw bits, all ones when ones == N.
    function automatic int qprob(input int ones, input int log2n, input int fracw);
        if (ones == (1 << log2n)) return (1 << fracw) - 1;
        return ones >> (log2n - fracw);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_conv();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_ones = 0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        model_ones += int'(b);
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic check_small(input string tag);
        chk({tag, "_rv_a"},   32'(rv_a),   32'd1);
        chk({tag, "_rv_b"},   32'(rv_b),   32'd1);
        chk({tag, "_br_a"},   32'(br_a),   32'd0);
        chk({tag, "_ones_a"}, 32'(ones_a), 32'(model_ones));
        chk({tag, "_ones_b"}, 32'(ones_b), 32'(model_ones));
        chk({tag, "_prob_a"}, 32'(prob_a), 32'(qprob(model_ones, 4, 4)));
        chk({tag, "_prob_b"}, 32'(prob_b), 32'(qprob(model_ones, 4, 2)));
    endtask

    initial begin
        logic b;
        int   sent;
        int   cyc;
        rst_s = 1'b1; rst_l = 1'b1;
        start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; result_ready = 1'b0;
        repeat (3) tick();
        chk("rst_br",   32'(br_a),   32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rv",   32'(rv_a),   32'd0);
        chk("rst_ones", 32'(ones_a), 32'd0);
        chk("rst_prob", 32'(prob_a), 32'd0);
        chk("rst_ones_c", 32'(ones_c), 32'd0);
        rst_s = 1'b0;

        // All-ones stream saturates the probability.
        start_conv();
        chk("t1_busy", 32'(busy_a), 32'd1);
        chk("t1_br",   32'(br_a),   32'd1);
        for (int i = 0; i < 16; i++) begin
            send_bit(1'b1);
            if (i == 14) chk("t1_rv_early", 32'(rv_a), 32'd0);
        end
        check_small("t1");
        chk("t1_busy_done", 32'(busy_a), 32'd0);
        consume();
        chk("t1_idle_rv",   32'(rv_a),   32'd0);
        chk("t1_idle_hold", 32'(ones_a), 32'd16);

        // Reset mid-stream discards the partial count and clears held results.
        start_conv();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        chk("t4_busy", 32'(busy_a), 32'd0);
        chk("t4_br",   32'(br_a),   32'd0);
        chk("t4_rv",   32'(rv_a),   32'd0);
        chk("t4_ones", 32'(ones_a), 32'd0);
        chk("t4_prob", 32'(prob_b), 32'd0);
        start_conv();
        for (int i = 0; i < 16; i++) send_bit(1'b1);
        check_small("t4b");

        // Held result is stable while the consumer stalls.
        for (int k = 0; k < 5; k++) begin
            start     = (k % 2 == 0);
            bit_valid = (k % 2 != 0);
            bit_in    = 1'b1;
            tick();
            chk("t5_rv",   32'(rv_a),   32'd1);
            chk("t5_br",   32'(br_a),   32'd0);
            chk("t5_ones", 32'(ones_a), 32'd16);
            chk("t5_prob", 32'(prob_a), 32'd15);
        end
        bit_valid = 1'b0; bit_in = 1'b0;
        start = 1'b1; result_ready = 1'b1;
        tick();
        start = 1'b0; result_ready = 1'b0;
        model_ones = 0;
        chk("t5_b2b_busy", 32'(busy_a), 32'd1);
        chk("t5_b2b_rv",   32'(rv_a),   32'd0);
        for (int i = 0; i < 16; i++) send_bit(i == 2 || i == 7 || i == 13);
        check_small("t5b");
        consume();

        // Alternating stream with a gap every third cycle.
        start_conv();
        sent = 0; cyc = 0;
        while (sent < 16) begin
            if (cyc % 3 == 2) begin
                tick();
                if (sent < 16) chk("t2_gap_rv", 32'(rv_a), 32'd0);
            end else begin
                send_bit(sent % 2 == 0);
                sent++;
            end
            cyc++;
        end
        check_small("t2");
        consume();
        start_conv();
        for (int i = 0; i < 16; i++) send_bit(1'b0);
        check_small("t2z");
        consume();

        // start raised during accumulation has no effect.
        start_conv();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) start = 1'b1;
            send_bit(1'($urandom & 1));
            start = 1'b0;
            if (i == 14) chk("t6_rv_early", 32'(rv_a), 32'd0);
        end
        check_small("t6");
        consume();

        // Random streams with random gaps.
        for (int r = 0; r < 6; r++) begin
            start_conv();
            sent = 0;
            while (sent < 16) begin
                if ($urandom % 4 == 0) tick();
                else begin
                    send_bit(1'($urandom & 1));
                    sent++;
                end
            end
            check_small("rnd");
            consume();
        end

        // Full-length stream on the default-size instance: AND of p=0.5 and p=0.75 streams.
        rst_s = 1'b1;
        rst_l = 1'b0;
        tick();
        start_conv();
        chk("t3_busy", 32'(busy_c), 32'd1);
        sent = 0;
        while (sent < 16384) begin
            if ($urandom % 16 == 0) tick();
            else begin
                b = 1'($urandom & 1) & 1'(($urandom % 4) != 0);
                send_bit(b);
                sent++;
                if (sent == 16383) chk("t3_rv_early", 32'(rv_c), 32'd0);
            end
        end
        chk("t3_rv",   32'(rv_c),   32'd1);
        chk("t3_ones", 32'(ones_c), 32'(model_ones));
        chk("t3_prob", 32'(prob_c), 32'(qprob(model_ones, 14, 8)));
        consume();
        chk("t3_idle", 32'(rv_c), 32'd0);
        chk("t3_hold", 32'(ones_c), 32'(model_ones));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
